div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Iterative radix-2 restoring divider with sequencer for RV32M DIV/DIVU/REM/REMU.
//  Sits in EX beside the commit mux. Takes one request per op, runs a multi-cycle FSM,
//  and returns the selected result over a valid/ready response.
//  rsp_valid drives the commit stage's div_type_ok; rsp_ready is fed by allow_in_wb.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; power of two, >=8 (from include.v `DATA_WIDTH)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-high
//  flush         in   1   pipeline kill; aborts in-flight op
//  req_valid     in   1   divide request valid (valid_ex & div_type)
//  req_ready     out  1   request accepted when req_valid & req_ready
//  div_control   in   3   bit2 signed, bit1 quotient, bit0 remainder: 001 REMU, 010 DIVU, 101 REM, 110 DIV
//  dividend      in   DW  rs1 value
//  divisor       in   DW  rs2 value
//  rsp_valid     out  1   result valid; held until rsp_ready
//  rsp_ready     in   1   consumer accepts result
//  div_res       out  DW  selected result (quotient or remainder per latched div_control)
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, div_res=0, busy=0, req_ready=1, all internal regs 0.
//  Other outputs: req_ready = (state==IDLE) & !flush.
//  Control codes 000/011/100/111 are illegal: the request is accepted and the result is 0 after 1 cycle.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: on accept, latch |operands| (two's-complement negate if signed & negative), sign flags,
//     and control. Zero the partial remainder, clear the counter, enter CALC.
//   IDLE special (accept edge): choose the special result and go straight to DONE.
//     divisor==0: q=all-ones, r=dividend.
//     signed, dividend==MIN, divisor==-1: q=MIN, r=0.
//   CALC: one restoring step per cycle (shift, trial subtract, set q bit).
//     Counter 0..DW-1; after the DW-th step go to FIX.
//   FIX: negate q if sign(dividend)^sign(divisor); negate r if sign(dividend).
//     Select q or r into div_res; go to DONE.
//   DONE: rsp_valid=1, div_res stable. On rsp_ready go to IDLE (rsp_valid low the next cycle).
//  Latency (accept edge = 0): normal op rsp_valid high after edge DW+2 (34 for DW=32);
//  special case after edge 1. Back-to-back issue costs one extra IDLE cycle.
//  Backpressure: in DONE with rsp_ready=0, hold rsp_valid and div_res unchanged indefinitely.
//  flush (synchronous, any state): next state IDLE, rsp_valid=0 next cycle.
//   flush+req_valid in same cycle: request is NOT accepted.
//   flush in DONE with rsp_ready=1: result is dropped.
//  rst mid-op: immediate return to reset values; no partial result escapes.
//  Arithmetic: partial remainder DW+1 bits; all negations are modulo 2^DW.
// CONFIGURATION
//  DIV_RESULT_CACHE_EN defined: on each FIX completion, store {dividend, divisor, signed bit, q, r}
//   in a 1-entry cache. A later request with equal operands and signed bit (either q or r select)
//   goes IDLE->DONE in 1 cycle with the cached value.
//   Cache is cleared by rst only; flush does not invalidate it; special-case results are not cached.
//  Undefined: no cache logic or storage; every non-special op takes DW+2 cycles.
// STRUCTURE
//  include.v: `DATA_WIDTH, DIV_CTRL_* code constants, DIV_ST_{IDLE,CALC,FIX,DONE} 2-bit state codes.
//  Sub-module div_restore_step: combinational single restoring iteration
//   ({rem,q} in, divisor in -> {rem,q} out). Instantiated once inside CALC.
// TESTING
//  T1 DIVU 100/7 -> rsp_valid at edge 34, div_res=14. REMU same operands -> 2.
//  T2 DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REM 7/-2 -> 1.
//  T3 DIVU 5/0 -> 0xFFFFFFFF at edge 1. REM 5/0 -> 5.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
//  T4 flush at edge 10 of CALC -> rsp_valid never rises, req_ready=1 at edge 11.
//     A new DIVU 9/3 issued then -> 3 at edge 34 after its own accept.
//  T5 rsp_ready held low 5 cycles in DONE -> rsp_valid/div_res stable all 5 cycles.
//     Single handshake, then IDLE.
//  T6 (DIV_RESULT_CACHE_EN) DIV 1000/33 then REM 1000/33 -> second response 1 cycle after accept, value 10.
//     Without the macro -> edge 34, value 10.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_seq_ctrl_pkg;

  localparam int unsigned DivDataWidth = 32;

  // div_control encodings: bit2 signed, bit1 quotient, bit0 remainder
  localparam logic [2:0] DivCtrlRemu = 3'b001;
  localparam logic [2:0] DivCtrlDivu = 3'b010;
  localparam logic [2:0] DivCtrlRem  = 3'b101;
  localparam logic [2:0] DivCtrlDiv  = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    return (ctrl == DivCtrlRemu) || (ctrl == DivCtrlDivu) ||
           (ctrl == DivCtrlRem)  || (ctrl == DivCtrlDiv);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DivDataWidth
) ();

  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            div_control;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] div_res;
  logic                  busy;

  modport master (
    output flush, req_valid, div_control, dividend, divisor, rsp_ready,
    input  req_ready, rsp_valid, div_res, busy
  );

  modport slave (
    input  flush, req_valid, div_control, dividend, divisor, rsp_ready,
    output req_ready, rsp_valid, div_res, busy
  );

endinterface

// File: rtl/div_seq_ctrl_restore_step.sv
// One radix-2 restoring division iteration (purely combinational).
module div_restore_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic [DATA_WIDTH-1:0] quo_in,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic [DATA_WIDTH-1:0] quo_out
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] trial;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign shifted = {rem_in, quo_in[DATA_WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs};

  // Keep the difference and set the quotient bit only when it did not go negative.
  always_comb begin
    if (trial[DATA_WIDTH+1]) begin
      rem_out = shifted[DATA_WIDTH:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial[DATA_WIDTH:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider with sequencer for DIV/DIVU/REM/REMU.
// Optional feature: define DIV_RESULT_CACHE_EN for a 1-entry result cache.
// rsp_valid is registered: it rises the cycle after the FSM reaches DONE.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DivDataWidth
) (
  input logic          clk,
  input logic          rst,
  div_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  div_state_e state_q, state_d;

  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  sel_quo_q, sel_quo_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  rsp_valid_q, rsp_valid_d;

`ifdef DIV_RESULT_CACHE_EN
  logic [DATA_WIDTH-1:0] raw_dvd_q, raw_dvd_d;
  logic [DATA_WIDTH-1:0] raw_dvs_q, raw_dvs_d;
  logic                  raw_sgn_q, raw_sgn_d;
  logic                  cache_valid_q, cache_valid_d;
  logic [DATA_WIDTH-1:0] cache_dvd_q, cache_dvd_d;
  logic [DATA_WIDTH-1:0] cache_dvs_q, cache_dvs_d;
  logic                  cache_sgn_q, cache_sgn_d;
  logic [DATA_WIDTH-1:0] cache_quo_q, cache_quo_d;
  logic [DATA_WIDTH-1:0] cache_rem_q, cache_rem_d;
  logic                  cache_hit;
`endif

  logic                  req_ready;
  logic                  accept;
  logic                  req_sgn;
  logic                  dvd_neg;
  logic                  dvs_neg;
  logic [DATA_WIDTH-1:0] dvd_abs;
  logic [DATA_WIDTH-1:0] dvs_abs;
  logic                  is_legal;
  logic                  dvs_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] fix_quo;
  logic [DATA_WIDTH-1:0] fix_rem;
  logic [DATA_WIDTH:0]   step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic                  unused_rem_msb;

  assign req_ready = (state_q == StIdle) & ~bus.flush;
  assign accept    = bus.req_valid & req_ready;

  assign req_sgn  = bus.div_control[2];
  assign dvd_neg  = req_sgn & bus.dividend[DATA_WIDTH-1];
  assign dvs_neg  = req_sgn & bus.divisor[DATA_WIDTH-1];
  assign dvd_abs  = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_abs  = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  assign is_legal = ctrl_legal(bus.div_control);
  assign dvs_zero = (bus.divisor == '0);
  assign overflow = req_sgn & (bus.dividend == MinVal) & (bus.divisor == '1);

  // The final remainder is always below the divisor, so its top bit is never set.
  assign fix_quo = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign fix_rem = neg_rem_q ? (~rem_q[DATA_WIDTH-1:0] + 1'b1) : rem_q[DATA_WIDTH-1:0];
  assign unused_rem_msb = rem_q[DATA_WIDTH];

`ifdef DIV_RESULT_CACHE_EN
  assign cache_hit = cache_valid_q & (cache_dvd_q == bus.dividend) &
                     (cache_dvs_q == bus.divisor) & (cache_sgn_q == req_sgn);
`endif

  div_restore_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    sel_quo_d   = sel_quo_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
`ifdef DIV_RESULT_CACHE_EN
    raw_dvd_d     = raw_dvd_q;
    raw_dvs_d     = raw_dvs_q;
    raw_sgn_d     = raw_sgn_q;
    cache_valid_d = cache_valid_q;
    cache_dvd_d   = cache_dvd_q;
    cache_dvs_d   = cache_dvs_q;
    cache_sgn_d   = cache_sgn_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          sel_quo_d = bus.div_control[1];
`ifdef DIV_RESULT_CACHE_EN
          raw_dvd_d = bus.dividend;
          raw_dvs_d = bus.divisor;
          raw_sgn_d = req_sgn;
`endif
          if (!is_legal) begin
            res_d   = '0;
            state_d = StDone;
          end else if (dvs_zero) begin
            res_d   = bus.div_control[1] ? '1 : bus.dividend;
            state_d = StDone;
          end else if (overflow) begin
            res_d   = bus.div_control[1] ? MinVal : '0;
            state_d = StDone;
`ifdef DIV_RESULT_CACHE_EN
          end else if (cache_hit) begin
            res_d   = bus.div_control[1] ? cache_quo_q : cache_rem_q;
            state_d = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        res_d   = sel_quo_q ? fix_quo : fix_rem;
        state_d = StDone;
`ifdef DIV_RESULT_CACHE_EN
        cache_valid_d = 1'b1;
        cache_dvd_d   = raw_dvd_q;
        cache_dvs_d   = raw_dvs_q;
        cache_sgn_d   = raw_sgn_q;
        cache_quo_d   = fix_quo;
        cache_rem_d   = fix_rem;
`endif
      end
      StDone: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A kill aborts whatever is in flight, including an unconsumed response.
    if (bus.flush) begin
      state_d     = StIdle;
      rsp_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      sel_quo_q   <= 1'b0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      sel_quo_q   <= sel_quo_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  // Result cache; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_dvd_q     <= '0;
      raw_dvs_q     <= '0;
      raw_sgn_q     <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_dvd_q   <= '0;
      cache_dvs_q   <= '0;
      cache_sgn_q   <= 1'b0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
    end else begin
      raw_dvd_q     <= raw_dvd_d;
      raw_dvs_q     <= raw_dvs_d;
      raw_sgn_q     <= raw_sgn_d;
      cache_valid_q <= cache_valid_d;
      cache_dvd_q   <= cache_dvd_d;
      cache_dvs_q   <= cache_dvs_d;
      cache_sgn_q   <= cache_sgn_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
    end
  end
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.div_res   = res_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
